// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller: FSM state
// encoding, register-port addresses, STAT field positions and the
// priority helper used to pick the next request.
package irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } irq_state_e;

  localparam logic [1:0] ADDR_MASK  = 2'd0;
  localparam logic [1:0] ADDR_PEND  = 2'd1;
  localparam logic [1:0] ADDR_EOI   = 2'd2;
  localparam logic [1:0] ADDR_VBASE = 2'd3;

  localparam int STAT_REQ_BIT  = 0;
  localparam int STAT_SERV_BIT = 1;
  localparam int STAT_ID_LSB   = 2;
  localparam int STAT_ID_MSB   = 3;
  localparam int STAT_SPUR_BIT = 4;

  // Index of the lowest set bit; lowest index is highest priority.
  // Returns 0 for an empty vector, callers qualify with |v.
  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] id;
    id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) id = 2'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the request lines. The history register resets
// to all ones so a line that is already high when reset releases is not
// mistaken for a fresh edge.
module irq_edge_detect #(
  parameter int NIRQ = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irq_i,
  output logic [NIRQ-1:0] rise_o
);

  logic [NIRQ-1:0] irq_q;

  // Previous-cycle copy of the request lines.
  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= '1;
    else        irq_q <= irq_i;
  end

  // One-cycle pulse for every low-to-high transition.
  always_comb begin
    rise_o = irq_i & ~irq_q;
  end

endmodule

// File: rtl/irq_controller.sv
// Prioritised interrupt controller. Latches request edges into PEND,
// presents the highest-priority enabled one to the CPU, holds it frozen
// through the acknowledge, and waits for an EOI write before the next.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NIRQ     = 4,
  parameter logic [15:0] VEC_BASE = 16'h0BB0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NIRQ-1:0] irq,
  output logic [2:0]      cpu_int,
  input  logic            intack,
  output logic [15:0]     vector,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_addr,
  input  logic [15:0]     cfg_wdata,
  output logic [15:0]     cfg_rdata
);

  irq_state_e      st_q, st_d;
  logic [1:0]      act_id_q, act_id_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [15:0]     vbase_q, vbase_d;
  logic            spur_q, spur_d;

  logic [NIRQ-1:0] rise;
  logic [NIRQ-1:0] grant_clr;
  logic [NIRQ-1:0] wr_clr;
  logic [3:0]      cand_ext;
  logic [1:0]      pick_id;
  logic            grant;
  logic            wr_eoi;

  irq_edge_detect #(.NIRQ(NIRQ)) u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .irq_i  (irq),
    .rise_o (rise)
  );

  // Enabled pending lines, widened to the 4-bit encoder input.
  always_comb begin
    cand_ext            = '0;
    cand_ext[NIRQ-1:0]  = pend_q & mask_q;
    pick_id             = lowest_set(cand_ext);
    wr_eoi              = cfg_we && (cfg_addr == ADDR_EOI);
  end

  // Request FSM: IDLE picks a candidate, REQ waits for intack, SERV for EOI.
  always_comb begin
    st_d     = st_q;
    act_id_d = act_id_q;
    spur_d   = spur_q;
    grant    = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (|cand_ext) begin
          grant    = 1'b1;
          act_id_d = pick_id;
          st_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (intack) st_d = ST_SERV;
      end
      ST_SERV: begin
        if (wr_eoi) begin
          st_d   = ST_IDLE;
          spur_d = 1'b0;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    // An acknowledge with nothing requested is recorded; it wins over EOI.
    if (intack && (st_q != ST_REQ)) spur_d = 1'b1;
  end

  // Pending bits: grant and software write-1 clear, a new edge always sets.
  always_comb begin
    grant_clr = '0;
    wr_clr    = '0;
    for (int i = 0; i < NIRQ; i++) begin
      grant_clr[i] = grant && (pick_id == 2'(i));
    end
    if (cfg_we && (cfg_addr == ADDR_PEND)) wr_clr = cfg_wdata[NIRQ-1:0];
    pend_d = (pend_q & ~(grant_clr | wr_clr)) | rise;
  end

  // Configuration register writes.
  always_comb begin
    mask_d  = mask_q;
    vbase_d = vbase_q;
    if (cfg_we && (cfg_addr == ADDR_MASK))  mask_d  = cfg_wdata[NIRQ-1:0];
    if (cfg_we && (cfg_addr == ADDR_VBASE)) vbase_d = cfg_wdata;
  end

  // State and register storage, all returned to known values on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      act_id_q <= 2'd0;
      pend_q   <= '0;
      mask_q   <= '0;
      vbase_q  <= VEC_BASE;
      spur_q   <= 1'b0;
    end else begin
      st_q     <= st_d;
      act_id_q <= act_id_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      vbase_q  <= vbase_d;
      spur_q   <= spur_d;
    end
  end

  // CPU-facing outputs; vector wraps modulo 2^16.
  always_comb begin
    cpu_int = {(st_q == ST_REQ), act_id_q};
    vector  = vbase_q + {14'b0, act_id_q};
  end

  // Combinational register read port.
  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      ADDR_MASK: cfg_rdata[NIRQ-1:0] = mask_q;
      ADDR_PEND: cfg_rdata[NIRQ-1:0] = pend_q;
      ADDR_EOI: begin
        cfg_rdata[STAT_REQ_BIT]              = (st_q == ST_REQ);
        cfg_rdata[STAT_SERV_BIT]             = (st_q == ST_SERV);
        cfg_rdata[STAT_ID_MSB:STAT_ID_LSB]   = act_id_q;
        cfg_rdata[STAT_SPUR_BIT]             = spur_q;
      end
      ADDR_VBASE: cfg_rdata = vbase_q;
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a transaction-level model tracks the
// controller's visible behaviour and is compared every cycle, and the
// directed scenarios carry hand-computed literal expectations.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq;
  logic [2:0]  cpu_int;
  logic        intack;
  logic [15:0] vector;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  irq_controller #(.NIRQ(4), .VEC_BASE(16'h0BB0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq       (irq),
    .cpu_int   (cpu_int),
    .intack    (intack),
    .vector    (vector),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = nothing outstanding, 1 = request shown, 2 = being serviced
  logic [3:0]  m_pend, m_mask, m_prev;
  logic [15:0] m_vbase;
  int          m_phase;
  logic [1:0]  m_id;
  logic        m_spur;

  always @(posedge clk) begin
    logic [3:0] rise, cand, np;
    int pick, oldph;
    if (!rst_n) begin
      m_pend = 4'h0; m_mask = 4'h0; m_prev = 4'hF;
      m_vbase = 16'h0BB0; m_phase = 0; m_id = 2'd0; m_spur = 1'b0;
    end else begin
      rise   = irq & ~m_prev;
      m_prev = irq;
      cand   = m_pend & m_mask;
      np     = m_pend;
      oldph  = m_phase;
      if (m_phase == 0 && cand != 4'h0) begin
        pick = -1;
        for (int i = 0; i < 4; i++) if (cand[i] && pick < 0) pick = i;
        m_id = 2'(pick);
        np[pick] = 1'b0;
        m_phase = 1;
      end else if (m_phase == 1 && intack) begin
        m_phase = 2;
      end else if (m_phase == 2 && cfg_we && cfg_addr == 2'd2) begin
        m_phase = 0;
        m_spur  = 1'b0;
      end
      if (intack && oldph != 1) m_spur = 1'b1;
      if (cfg_we) begin
        case (cfg_addr)
          2'd0: m_mask = cfg_wdata[3:0];
          2'd1: np = np & ~cfg_wdata[3:0];
          2'd3: m_vbase = cfg_wdata;
          default: ;
        endcase
      end
      m_pend = np | rise;
    end
  end

  function automatic logic [15:0] m_rdata(input logic [1:0] a);
    case (a)
      2'd0: return {12'b0, m_mask};
      2'd1: return {12'b0, m_pend};
      2'd2: return {11'b0, m_spur, m_id, (m_phase == 2), (m_phase == 1)};
      default: return m_vbase;
    endcase
  endfunction

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_cpu_int", {13'b0, cpu_int}, {13'b0, (m_phase == 1), m_id});
      chk("model_vector", vector, m_vbase + {14'b0, m_id});
      chk("model_rdata", cfg_rdata, m_rdata(cfg_addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0;
  endtask

  task automatic pulse(input logic [3:0] b);
    irq = irq | b;
    tick();
    irq = irq & ~b;
  endtask

  task automatic ack();
    intack = 1'b1;
    tick();
    intack = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input string name, input logic [15:0] exp);
    cfg_addr = a;
    #1;
    chk(name, cfg_rdata, exp);
    cfg_addr = 2'd0;
  endtask

  task automatic lit_int(input string name, input logic [2:0] exp);
    chk(name, {13'b0, cpu_int}, {13'b0, exp});
  endtask

  initial begin
    rst_n = 1'b0; irq = 4'h0; intack = 1'b0;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0;
    tick(); tick();
    chk_en = 1'b1;
    // reset state
    lit_int("rst_cpu_int", 3'b000);
    chk("rst_vector", vector, 16'h0BB0);
    rd(2'd0, "rst_mask", 16'h0000);
    rd(2'd2, "rst_stat", 16'h0000);
    rst_n = 1'b1;
    tick();

    // basic request / ack / EOI
    wr(2'd0, 16'h0006);
    pulse(4'b0100);
    lit_int("t1_not_yet", 3'b000);
    rd(2'd1, "t1_pend", 16'h0004);
    tick();
    lit_int("t1_req", 3'b110);
    chk("t1_vector", vector, 16'h0BB2);
    ack();
    lit_int("t1_after_ack", 3'b010);
    rd(2'd2, "t1_stat_serv", 16'h000A);
    wr(2'd2, 16'h0000);
    rd(2'd2, "t1_stat_idle", 16'h0008);

    // simultaneous edges, priority
    wr(2'd0, 16'h000F);
    pulse(4'b0110);
    tick();
    lit_int("t2_first", 3'b101);
    chk("t2_vec1", vector, 16'h0BB1);
    ack();
    wr(2'd2, 16'h0000);
    tick();
    lit_int("t2_second", 3'b110);
    chk("t2_vec2", vector, 16'h0BB2);
    ack();
    wr(2'd2, 16'h0000);

    // masked line, later enable, and cleared-before-enable
    wr(2'd0, 16'h0000);
    pulse(4'b1000);
    tick();
    lit_int("t3_masked", 3'b010);
    rd(2'd1, "t3_pend", 16'h0008);
    wr(2'd0, 16'h0008);
    lit_int("t3_enable_edge", 3'b010);
    tick();
    lit_int("t3_req", 3'b111);
    ack();
    wr(2'd2, 16'h0000);
    wr(2'd0, 16'h0000);
    pulse(4'b1000);
    rd(2'd1, "t3b_pend", 16'h0008);
    wr(2'd1, 16'h0008);
    wr(2'd0, 16'h0008);
    tick();
    lit_int("t3b_dropped", 3'b011);
    rd(2'd1, "t3b_pend_clr", 16'h0000);

    // frozen request while higher priority arrives
    wr(2'd0, 16'h000F);
    pulse(4'b0100);
    tick();
    lit_int("t4_req2", 3'b110);
    pulse(4'b0001);
    lit_int("t4_frozen_a", 3'b110);
    tick();
    lit_int("t4_frozen_b", 3'b110);
    intack = 1'b1;
    #1;
    lit_int("t4_at_ack", 3'b110);
    chk("t4_vec_ack", vector, 16'h0BB2);
    @(posedge clk); #1;
    intack = 1'b0;
    lit_int("t4_serv", 3'b010);
    wr(2'd2, 16'h0000);
    tick();
    lit_int("t4_req0", 3'b100);
    chk("t4_vec0", vector, 16'h0BB0);
    ack();
    wr(2'd2, 16'h0000);

    // vector wrap and spurious acknowledge
    wr(2'd3, 16'hFFFE);
    pulse(4'b1000);
    tick();
    lit_int("t5_req3", 3'b111);
    chk("t5_wrap", vector, 16'h0001);
    ack();
    wr(2'd2, 16'h0000);
    ack();
    rd(2'd2, "t5_spurious", 16'h001C);

    // PEND write-1 and an edge on the same bit: set wins
    wr(2'd0, 16'h0000);
    cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 16'h0002; irq = 4'b0010;
    tick();
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 16'h0; irq = 4'b0000;
    rd(2'd1, "t5_set_wins", 16'h0002);
    wr(2'd1, 16'h0002);

    // line held high through reset, then reset in the middle of REQ
    irq = 4'b0001; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    rd(2'd1, "t6_no_pend", 16'h0000);
    irq = 4'b0000;
    wr(2'd0, 16'h0004);
    pulse(4'b0100);
    tick();
    lit_int("t6_req", 3'b110);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lit_int("t6_rst_cpu_int", 3'b000);
    chk("t6_rst_vector", vector, 16'h0BB0);
    rd(2'd0, "t6_rst_mask", 16'h0000);
    rd(2'd2, "t6_rst_stat", 16'h0000);
    rd(2'd3, "t6_rst_vbase", 16'h0BB0);
    tick(); tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
